dff_serializer: RTL and testbench

Parallel-to-serial bit transmitter that converts WIDTH-bit words into a one-bit-per-clock stream for the single-bit `din` input of the flip-flop stage. It sits upstream of the DFF data path as its stream source. Upstream logic hands it words over a valid/ready handshake. It shifts each word out with a per-bit valid flag and an end-of-word pulse, and supports back-to-back words with no idle cycle.

---
 rtl/dff_serializer_pkg.sv | 14 +
 rtl/dff_serializer_if.sv | 24 ++
 rtl/dff_serializer.sv | 85 ++++++++
 tb/tb_dff_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_serializer_pkg.sv
// Shared types for the parallel-to-serial stream source feeding the DFF data path.
// Both the RTL and the bench import this package.
package dff_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   localparam int SER_WIDTH = 8;

   typedef logic [SER_WIDTH-1:0] ser_word_t;

endpackage

// File: rtl/dff_serializer_if.sv
// Word-in / bit-out bundle for dff_serializer.
// The upstream word source drives the master side; the serializer is the slave.
interface dff_ser_interface
   import dff_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             dout;
   logic             dout_valid;
   logic             done;

   modport master (
      output din, din_valid,
      input  din_ready, dout, dout_valid, done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, dout, dout_valid, done
   );
endinterface

// File: rtl/dff_serializer.sv
// Shifts WIDTH-bit words out one bit per clock, with a per-bit valid flag and an
// end-of-word pulse. A new word may load on the last bit of the previous one.
module dff_serializer
   import dff_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   dff_ser_interface.slave  bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   ser_state_e        r_state;
   ser_state_e        w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [WIDTH-1:0]  r_sreg;
   logic [WIDTH-1:0]  w_sreg_nxt;
   logic              w_last;
   logic              w_accept;
   logic              w_head;

   assign w_last        = (r_state == SHIFT) && (r_cnt == LAST);
   // Ready on the last bit is what lets back-to-back words run without a bubble.
   assign bus.din_ready = rst && ((r_state == IDLE) || w_last);
   assign w_accept      = bus.din_valid && bus.din_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sreg_nxt  = r_sreg;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_cnt_nxt   = '0;
               w_sreg_nxt  = bus.din;
            end
         end
         SHIFT: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_cnt_nxt   = '0;
               w_sreg_nxt  = bus.din;
            end else if (w_last) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_sreg_nxt  = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
               if (LSB_FIRST) w_sreg_nxt = {1'b0, r_sreg[WIDTH-1:1]};
               else           w_sreg_nxt = {r_sreg[WIDTH-2:0], 1'b0};
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_sreg_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sreg  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sreg  <= w_sreg_nxt;
      end
   end

   // Outputs come straight off state registers, so reset clears them immediately.
   assign w_head         = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];
   assign bus.dout_valid = (r_state == SHIFT);
   assign bus.dout       = (r_state == SHIFT) && w_head;
   assign bus.done       = w_last;

endmodule

// File: tb/tb_dff_serializer.sv
// Bench for dff_serializer: three instances (MSB-first 8b, LSB-first 8b, MSB-first 5b)
// checked every cycle against a queue-of-expected-bits model, plus literal pins.
module tb_dff_serializer;
   import dff_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dff_ser_interface #(.WIDTH(8)) ifa ();
   dff_ser_interface #(.WIDTH(8)) ifb ();
   dff_ser_interface #(.WIDTH(5)) ifc ();

   dff_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   dff_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
   dff_serializer #(.WIDTH(5), .LSB_FIRST(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

   logic [7:0] dinw [3];
   logic       dvld [3];
   logic       rdy  [3];
   logic       so   [3];
   logic       sov  [3];
   logic       sdn  [3];

   assign dinw[0] = ifa.din;            assign dinw[1] = ifb.din;
   assign dinw[2] = {3'b000, ifc.din};
   assign dvld[0] = ifa.din_valid;      assign dvld[1] = ifb.din_valid;      assign dvld[2] = ifc.din_valid;
   assign rdy[0]  = ifa.din_ready;      assign rdy[1]  = ifb.din_ready;      assign rdy[2]  = ifc.din_ready;
   assign so[0]   = ifa.dout;           assign so[1]   = ifb.dout;           assign so[2]   = ifc.dout;
   assign sov[0]  = ifa.dout_valid;     assign sov[1]  = ifb.dout_valid;     assign sov[2]  = ifc.dout_valid;
   assign sdn[0]  = ifa.done;           assign sdn[1]  = ifb.done;           assign sdn[2]  = ifc.done;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int wid(input int i);
      return (i == 2) ? 5 : 8;
   endfunction

   function automatic bit lsbf(input int i);
      return (i == 1);
   endfunction

   task automatic set_in(input int i, input logic v, input logic [7:0] d);
      case (i)
         0: begin ifa.din_valid = v; ifa.din = d; end
         1: begin ifb.din_valid = v; ifb.din = d; end
         default: begin ifc.din_valid = v; ifc.din = d[4:0]; end
      endcase
   endtask

   // Model: each accepted word becomes WIDTH queued {last, bit} entries, one per cycle.
   logic [1:0] expq [3][$];
   logic [7:0] sentq[$];

   always @(negedge clk) begin : model_cmp
      logic       mrdy;
      logic [1:0] e;
      int         b;
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            expq[i].delete();
            chk("reset_outputs", {28'd0, rdy[i], so[i], sov[i], sdn[i]}, 32'd0);
         end else begin
            mrdy = (expq[i].size() <= 1);
            if (expq[i].size() > 0) begin
               e = expq[i].pop_front();
               chk("stream_bit", {29'd0, sov[i], so[i], sdn[i]}, {29'd0, 1'b1, e[0], e[1]});
            end else begin
               chk("idle_out", {29'd0, sov[i], so[i], sdn[i]}, 32'd0);
            end
            chk("din_ready", {31'd0, rdy[i]}, {31'd0, mrdy});
            if (dvld[i] && mrdy) begin
               for (int k = 0; k < wid(i); k++) begin
                  b = lsbf(i) ? k : wid(i) - 1 - k;
                  expq[i].push_back({(k == wid(i) - 1), dinw[i][b]});
               end
               if (i == 2) sentq.push_back(dinw[2]);
            end
         end
      end
   end

   // Independent word reassembly for the 5-bit instance.
   logic [7:0] racc   = '0;
   int         rnb    = 0;
   int         rwords = 0;
   logic [7:0] rexp;

   always @(negedge clk) begin
      if (!rst) begin
         rnb = 0;
         racc = '0;
      end else if (sov[2]) begin
         racc = {racc[6:0], so[2]};
         rnb++;
         if (sdn[2]) begin
            rexp = (sentq.size() > 0) ? sentq.pop_front() : 8'hxx;
            chk("reasm_len", rnb, 5);
            chk("reasm_word", {27'd0, racc[4:0]}, {27'd0, rexp[4:0]});
            rwords++;
            rnb = 0;
         end
      end
   end

   task automatic run_word(input int i, input logic [7:0] w, input int n,
                           output logic [31:0] bits, output logic [31:0] vs,
                           output logic [31:0] dns, output logic [31:0] rds);
      bits = '0; vs = '0; dns = '0; rds = '0;
      @(posedge clk); #1 set_in(i, 1'b1, w);
      @(negedge clk);
      @(posedge clk); #1 set_in(i, 1'b0, 8'h00);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bits = {bits[30:0], so[i]};
         vs   = {vs[30:0], sov[i]};
         dns  = {dns[30:0], sdn[i]};
         rds  = {rds[30:0], rdy[i]};
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b, v, d, r;
      logic [31:0] cb, cv, cd;
      bit          got;
      bit          take;
      int          acc_cnt;
      int          cyc;
      logic [7:0]  w;

      for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1 chk("ready_in_reset", {31'd0, rdy[0]}, 32'd0);
      rst = 1'b1;
      #1 chk("ready_after_release", {31'd0, rdy[0]}, 32'd1);

      // MSB-first A5
      run_word(0, 8'hA5, 8, b, v, d, r);
      chk("a5_bits",  b, 32'hA5);
      chk("a5_valid", v, 32'hFF);
      chk("a5_done",  d, 32'h01);
      chk("a5_ready", r, 32'h01);
      @(negedge clk);
      chk("a5_tail_valid", {31'd0, sov[0]}, 32'd0);

      // LSB-first 01
      run_word(1, 8'h01, 8, b, v, d, r);
      chk("lsb01_bits", b, 32'h80);
      chk("lsb01_done", d, 32'h01);

      // Back-to-back FF then 00
      cb = '0; cv = '0; cd = '0; got = 1'b0;
      @(posedge clk); #1 set_in(0, 1'b1, 8'hFF);
      fork
         begin
            @(posedge clk);
            for (int k = 0; k < 17; k++) begin
               @(negedge clk);
               cb = {cb[30:0], so[0]};
               cv = {cv[30:0], sov[0]};
               cd = {cd[30:0], sdn[0]};
            end
         end
         begin
            @(posedge clk); #1 set_in(0, 1'b1, 8'h00);
            for (int k = 0; k < 20 && !got; k++) begin
               @(negedge clk);
               if (rdy[0]) got = 1'b1;
            end
            @(posedge clk); #1 set_in(0, 1'b0, 8'h00);
         end
      join
      chk("b2b_accepted", {31'd0, got}, 32'd1);
      chk("b2b_valid", cv, 32'h1FFFE);
      chk("b2b_bits",  cb, 32'h1FE00);
      chk("b2b_done",  cd, 32'h00202);

      // Reset mid-word of C3, then 3C from bit 0
      run_word(0, 8'hC3, 4, b, v, d, r);
      chk("c3_first4", b, 32'hC);
      @(posedge clk); #2 rst = 1'b0;
      #1 chk("mid_reset_out", {28'd0, so[0], sov[0], sdn[0], rdy[0]}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      run_word(0, 8'h3C, 8, b, v, d, r);
      chk("3c_bits", b, 32'h3C);
      chk("3c_done", d, 32'h01);

      // 200 random 5-bit words with random din_valid
      acc_cnt = 0; cyc = 0;
      rwords = 0;
      w = 8'($urandom_range(0, 31));
      @(posedge clk); #1 set_in(2, 1'b1, w);
      while (acc_cnt < 200 && cyc < 6000) begin
         @(negedge clk);
         take = dvld[2] && rdy[2];
         @(posedge clk); #1;
         if (take) begin
            acc_cnt++;
            w = 8'($urandom_range(0, 31));
         end
         if (acc_cnt < 200) set_in(2, ($urandom_range(0, 2) != 0), w);
         else               set_in(2, 1'b0, 8'h00);
         cyc++;
      end
      set_in(2, 1'b0, 8'h00);
      repeat (10) @(posedge clk);
      chk("rand_accepted", acc_cnt, 200);
      chk("rand_words", rwords, 200);
      chk("rand_pending", sentq.size(), 0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
